// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO.
package ram_fifo_pkg;

  localparam int FIFO_ADDR_WIDTH_DEFAULT = 8;
  localparam int FIFO_DATA_WIDTH_DEFAULT = 8;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/ram_dualport.sv
// True dual-port RAM with registered read on both ports; contents are never cleared.
module ram_dualport #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  in_clk,
  input  logic                  in_wr_a,
  input  logic [ADDR_WIDTH-1:0] in_addr_a,
  input  logic [DATA_WIDTH-1:0] in_data_a,
  output logic [DATA_WIDTH-1:0] out_data_a,
  input  logic                  in_wr_b,
  input  logic [ADDR_WIDTH-1:0] in_addr_b,
  input  logic [DATA_WIDTH-1:0] in_data_b,
  output logic [DATA_WIDTH-1:0] out_data_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] data_a_q;
  logic [DATA_WIDTH-1:0] data_b_q;

  always_ff @(posedge in_clk) begin
    if (in_wr_a) mem[in_addr_a] <= in_data_a;
    if (in_wr_b) mem[in_addr_b] <= in_data_b;
    data_a_q <= mem[in_addr_a];
    data_b_q <= mem[in_addr_b];
  end

  assign out_data_a = data_a_q;
  assign out_data_b = data_b_q;

endmodule

// File: rtl/ram_fifo.sv
// Synchronous FIFO on a dual-port RAM with one-cycle read latency.
// Define RAM_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow flags.
module ram_fifo
  import ram_fifo_pkg::*;
#(
  parameter int FIFO_ADDR_WIDTH = FIFO_ADDR_WIDTH_DEFAULT,
  parameter int FIFO_DATA_WIDTH = FIFO_DATA_WIDTH_DEFAULT
) (
  input  logic                       in_clk,
  input  logic                       in_rst_n,
  input  logic                       in_wr_en,
  input  logic [FIFO_DATA_WIDTH-1:0] in_wr_data,
  input  logic                       in_rd_en,
  output logic [FIFO_DATA_WIDTH-1:0] out_rd_data,
  output logic                       out_rd_valid,
  output logic                       out_full,
  output logic                       out_empty,
  output logic [FIFO_ADDR_WIDTH:0]   out_count
`ifdef RAM_FIFO_ERR_FLAGS_EN
  ,
  input  logic                       in_clr_err,
  output logic                       out_overflow,
  output logic                       out_underflow
`endif
);

  localparam int PW = ptr_width(FIFO_ADDR_WIDTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          rd_valid_q;
  logic          push, pop;
  logic [FIFO_DATA_WIDTH-1:0] unused_rdata_a;

  // Acceptance depends only on registered flags, so there is no fall-through.
  assign push = in_wr_en & ~full_q;
  assign pop  = in_rd_en & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase
    full_d  = (wr_ptr_d[FIFO_ADDR_WIDTH-1:0] == rd_ptr_d[FIFO_ADDR_WIDTH-1:0]) &&
              (wr_ptr_d[FIFO_ADDR_WIDTH] != rd_ptr_d[FIFO_ADDR_WIDTH]);
    empty_d = (wr_ptr_d == rd_ptr_d);
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      rd_valid_q <= pop;
    end
  end

  ram_dualport #(
    .ADDR_WIDTH(FIFO_ADDR_WIDTH),
    .DATA_WIDTH(FIFO_DATA_WIDTH)
  ) u_ram (
    .in_clk    (in_clk),
    .in_wr_a   (push),
    .in_addr_a (wr_ptr_q[FIFO_ADDR_WIDTH-1:0]),
    .in_data_a (in_wr_data),
    .out_data_a(unused_rdata_a),
    .in_wr_b   (1'b0),
    .in_addr_b (rd_ptr_q[FIFO_ADDR_WIDTH-1:0]),
    .in_data_b ('0),
    .out_data_b(out_rd_data)
  );

  assign out_rd_valid = rd_valid_q;
  assign out_full     = full_q;
  assign out_empty    = empty_q;
  assign out_count    = count_q;

`ifdef RAM_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // A refusal in the same cycle as a clear keeps the flag set.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (in_clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (in_wr_en && full_q)  overflow_d  = 1'b1;
    if (in_rd_en && empty_q) underflow_d = 1'b1;
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign out_overflow  = overflow_q;
  assign out_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_ram_fifo;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef RAM_FIFO_ERR_FLAGS_EN
  logic          clr_err = 1'b0;
  logic          overflow;
  logic          underflow;
`endif

  ram_fifo #(
    .FIFO_ADDR_WIDTH(AW),
    .FIFO_DATA_WIDTH(DW)
  ) dut (
    .in_clk      (clk),
    .in_rst_n    (rst_n),
    .in_wr_en    (wr_en),
    .in_wr_data  (wr_data),
    .in_rd_en    (rd_en),
    .out_rd_data (rd_data),
    .out_rd_valid(rd_valid),
    .out_full    (full),
    .out_empty   (empty),
    .out_count   (count)
`ifdef RAM_FIFO_ERR_FLAGS_EN
    ,
    .in_clr_err   (clr_err),
    .out_overflow (overflow),
    .out_underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a queue of stored entries plus expected flag state.
  logic [DW-1:0] model_q[$];
  logic          exp_valid = 1'b0;
  logic [DW-1:0] exp_data = '0;
  logic          exp_ovf = 1'b0;
  logic          exp_unf = 1'b0;

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          rd;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_count;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, advance the model, step past the edge.
  task automatic cycle(input logic wr, input logic [DW-1:0] d, input logic rd, input logic clr);
    bit push_ok, pop_ok, set_o, set_u;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
`ifdef RAM_FIFO_ERR_FLAGS_EN
    clr_err = clr;
`endif
    push_ok = wr && (model_q.size() < DEPTH);
    pop_ok  = rd && (model_q.size() > 0);
    set_o   = wr && (model_q.size() == DEPTH);
    set_u   = rd && (model_q.size() == 0);
    exp_ovf = set_o ? 1'b1 : (clr ? 1'b0 : exp_ovf);
    exp_unf = set_u ? 1'b1 : (clr ? 1'b0 : exp_unf);
    exp_valid = pop_ok;
    if (pop_ok) exp_data = model_q.pop_front();
    if (push_ok) model_q.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
`ifdef RAM_FIFO_ERR_FLAGS_EN
    clr_err = 1'b0;
`endif
    $display("t=%0t wr=%0b rd=%0b d=%02h -> valid=%0b q=%02h count=%0d full=%0b empty=%0b",
             $time, wr, rd, d, rd_valid, rd_data, count, full, empty);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(rd_valid), 32'(exp_valid));
    if (exp_valid) chk({tag, "_data"}, 32'(rd_data), 32'(exp_data));
    chk({tag, "_count"}, 32'(count), 32'(model_q.size()));
    chk({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
    chk({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
`ifdef RAM_FIFO_ERR_FLAGS_EN
    chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    chk({tag, "_unf"}, 32'(underflow), 32'(exp_unf));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_count"}, 32'(count), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
`ifdef RAM_FIFO_ERR_FLAGS_EN
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_unf"}, 32'(underflow), 32'd0);
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_q.delete();
    exp_valid = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    check_reset_outputs("rst_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int pushed;
    int cyc;
    bit filling;
    logic w, r;

    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 8'h00, 2};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 3};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 2};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 0};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed table: push three, pop three, then pop on empty
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].wr, tbl[i].d, tbl[i].rd, 1'b0);
      chk($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
      chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
    end
    chk("tbl_end_empty", 32'(empty), 32'd1);

    // Fill to full, refused push, push+pop while full, drain
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
      check_all("fill");
    end
    chk("full_flag", 32'(full), 32'd1);
    chk("full_count", 32'(count), 32'(DEPTH));
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    check_all("push_when_full");
    chk("dropped_count", 32'(count), 32'(DEPTH));
    cycle(1'b1, 8'hDD, 1'b1, 1'b0);
    check_all("pushpop_when_full");
    while (model_q.size() > 0) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      check_all("drain");
    end

    // Simultaneous push and pop at count 5 for ten cycles
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, DW'(8'h50 + i), 1'b0, 1'b0);
      check_all("pre5");
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, DW'($urandom), 1'b1, 1'b0);
      check_all("steady5");
      chk("steady5_cnt", 32'(count), 32'd5);
    end

    // Push and pop on an empty FIFO: only the push is taken
    do_reset();
    cycle(1'b1, 8'hA5, 1'b1, 1'b0);
    check_all("empty_wr_rd");
    chk("empty_wr_rd_count", 32'(count), 32'd1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    check_all("unf_hold");
    cycle(1'b0, '0, 1'b0, 1'b1);
    check_all("unf_clr");
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_all("pop_last");

    // Randomized oscillation 0..200 with wrapping pointers
    do_reset();
    pushed  = 0;
    filling = 1'b1;
    cyc     = 0;
    while ((pushed < 600 || model_q.size() > 0) && cyc < 20000) begin
      if (model_q.size() >= 200) filling = 1'b0;
      if (model_q.size() == 0) filling = 1'b1;
      w = (pushed < 600) && (filling ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
      r = filling ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      if (w && model_q.size() < DEPTH) pushed++;
      cycle(w, DW'($urandom), r, 1'b0);
      check_all("rand");
      cyc++;
    end
    chk("rand_pushed", 32'(pushed), 32'd600);
    chk("rand_drained", 32'(model_q.size()), 32'd0);

    // Reset mid-burst at count 7 with a pop in flight
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, DW'(8'h70 + i), 1'b0, 1'b0);
      check_all("pre7");
    end
    cycle(1'b0, '0, 1'b1, 1'b0);
    check_all("pop_inflight");
    rd_en = 1'b1;
    #2;
    rst_n = 1'b0;
    model_q.delete();
    exp_valid = 1'b0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_held");
    rd_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, '0, 1'b0, 1'b0);
      check_all("post_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_fifo.md
RAM_FIFO -- requirements
Module: ram_fifo

Interface
REQ-001 Parameter FIFO_ADDR_WIDTH SHALL default to 8; it sets the depth to 2**FIFO_ADDR_WIDTH entries.
REQ-002 Parameter FIFO_DATA_WIDTH SHALL default to 8; it is the entry width in bits.
REQ-003 in_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 in_rst_n  input  1  SHALL be the reset: asynchronous assert, active-low.
REQ-005 in_wr_en  input  1  SHALL request a push of in_wr_data.
REQ-006 in_wr_data  input  FIFO_DATA_WIDTH  SHALL be the push data, sampled when a push is accepted.
REQ-007 in_rd_en  input  1  SHALL request a pop.
REQ-008 out_rd_data  output  FIFO_DATA_WIDTH  SHALL be the popped data, meaningful only while out_rd_valid=1.
REQ-009 out_rd_valid  output  1  SHALL mark the cycle in which out_rd_data is valid.
REQ-010 out_full  output  1  SHALL be high when count equals depth.
REQ-011 out_empty  output  1  SHALL be high when count equals 0.
REQ-012 out_count  output  FIFO_ADDR_WIDTH+1  SHALL be the number of stored entries, 0..depth.

Function
REQ-013 A push SHALL be accepted iff in_wr_en=1 and out_full=0; a pop SHALL be accepted iff in_rd_en=1 and out_empty=0.
REQ-014 An accepted push SHALL write in_wr_data at the write pointer through storage port A and increment the write pointer.
REQ-015 An accepted pop SHALL present the read pointer to storage port B and increment the read pointer.
REQ-016 out_rd_valid SHALL go high exactly one cycle after an accepted pop, for one cycle per pop; back-to-back pops SHALL give back-to-back valids.
REQ-017 Pointers SHALL be FIFO_ADDR_WIDTH+1 bits; the low bits address storage, and wrap from depth-1 to 0 is silent.
REQ-018 Full SHALL be detected as equal low bits with differing MSB; empty SHALL be detected as fully equal pointers.
REQ-019 out_count, out_full and out_empty SHALL be registered and reflect the accepted operations on the next edge: +1 for push only, -1 for pop only, unchanged for both.
REQ-020 Simultaneous push and pop with 0<count<depth SHALL both be accepted, leaving count unchanged.
REQ-021 A push while full, even with in_rd_en=1, SHALL be dropped; a pop while empty, even with in_wr_en=1, SHALL be ignored with no out_rd_valid. There is no fall-through.
REQ-022 Because of REQ-021, ports A and B SHALL never address the same entry in the same cycle with a write.
REQ-023 Data SHALL be returned in push order.

Reset
REQ-024 While in_rst_n=0: pointers=0, out_count=0, out_empty=1, out_full=0, out_rd_valid=0.
REQ-025 out_rd_data SHALL be don't-care after reset; storage contents SHALL NOT be cleared.
REQ-026 A reset asserted mid-operation SHALL discard all entries and any pending out_rd_valid immediately.

Configuration
REQ-027 Macro RAM_FIFO_ERR_FLAGS_EN SHALL, when defined, add the following ports:
- out_overflow (1 bit): sticky, set by a push refused because of full.
- out_underflow (1 bit): sticky, set by a pop refused because of empty.
- in_clr_err (1 bit): synchronous clear of both flags; a set in the same cycle wins.
- Both flags reset to 0.
REQ-028 Without RAM_FIFO_ERR_FLAGS_EN those ports and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-029 A shared package SHALL hold the default width constants and the pointer-width function (FIFO_ADDR_WIDTH+1).
REQ-030 Storage SHALL be one instance of the existing ram_dualport module:
- Port A: write, with in_wr_a = accepted push.
- Port B: read-only, with in_wr_b tied 0 and in_data_b tied 0.
- Port A read data unused.
REQ-031 Pointer, flag and count logic SHALL live in ram_fifo itself; no further sub-modules.

Verification
REQ-032 Reset, then push 0x11,0x22,0x33 on consecutive cycles, then pop 3 -> out_rd_data 0x11,0x22,0x33 on consecutive out_rd_valid cycles; out_count 3 then 0; out_empty=1 at end.
REQ-033 Push 256 entries (default depth) -> out_full=1, out_count=256; a 257th push is dropped and count stays 256; with ERR_FLAGS_EN, out_overflow=1.
REQ-034 At count=5, hold in_wr_en and in_rd_en high for 10 cycles -> count stays 5; 10 valids in order.
REQ-035 Empty FIFO with in_rd_en=1 and in_wr_en=1 for one cycle -> no out_rd_valid, count becomes 1; with ERR_FLAGS_EN, out_underflow=1 until in_clr_err.
REQ-036 Push/pop 600 entries with count oscillating 0..200 -> pointers wrap, all data matches the scoreboard.
REQ-037 Assert in_rst_n=0 mid-burst at count=7 with a pop in flight -> outputs take reset values asynchronously and no out_rd_valid follows.
